keypad_number_entry: RTL and testbench

KEYPAD_NUMBER_ENTRY -- requirements
Module: keypad_number_entry

---
 rtl/keypad_number_entry.sv | 267 ++++++++++++++++++++++++++
 tb/tb_keypad_number_entry.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_number_entry.sv
// -----------------------------------------------------------------------------
// keypad_number_entry
//
// Scans a 4x4 matrix keypad, debounces presses and releases, and builds a
// decimal number of up to four digits. '#' commits the number, '*' clears it.
//
// Keypad layout (key code = row_index*4 + col_index):
//   row 0: 1 2 3 A   row 1: 4 5 6 B   row 2: 7 8 9 C   row 3: * 0 # D
//
// Optional feature: define KEYPAD_BACKSPACE_EN to make 'D' delete the last
// typed digit. Without it, 'D' only produces key_pulse.
//
// Parameters:
//   SCAN_DIV        clk_100mhz cycles each keypad row is driven
//   DEBOUNCE_CYCLES consecutive stable cycles required for press and release
//
// Ports:
//   clk_100mhz      single clock, rising edge
//   reset           asynchronous active-low reset (0 = reset)
//   col_in[3:0]     keypad columns, active-low, asynchronous
//   row_out[3:0]    keypad row drive, active-low one-cold
//   accum_number    binary value of the digits being typed
//   digit_count     number of digits in accum_number (0-4)
//   entered_number  last committed value, held until the next commit
//   number_valid    one-cycle pulse when entered_number updates
//   key_code        code of the last accepted key
//   key_pulse       one-cycle strobe per accepted press
// -----------------------------------------------------------------------------
module keypad_number_entry #(
  parameter int SCAN_DIV        = 100000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clk_100mhz,
  input  logic        reset,
  input  logic [3:0]  col_in,
  output logic [3:0]  row_out,
  output logic [15:0] accum_number,
  output logic [2:0]  digit_count,
  output logic [15:0] entered_number,
  output logic        number_valid,
  output logic [3:0]  key_code,
  output logic        key_pulse
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [3:0] KEY_STAR = 4'd12;
  localparam logic [3:0] KEY_HASH = 4'd14;
`ifdef KEYPAD_BACKSPACE_EN
  localparam logic [3:0] KEY_D    = 4'd15;
`endif

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    ACCEPT,
    WAIT_RELEASE
  } state_t;

  state_t state, state_next;

  logic [1:0]        run_sync;
  logic              run;
  logic [3:0]        col_meta, col_sync;
  logic [1:0]        row_idx;
  logic [SCAN_W-1:0] scan_cnt;
  logic [1:0]        settle_cnt;
  logic [DEB_W-1:0]  deb_cnt;
  logic [3:0]        cand_code;
  logic [1:0]        col_idx;
  logic              col_any;
  logic [3:0]        cur_code;
  logic              capture;
  logic              accept_now;
  logic              row_advance;
  logic [4:0]        cand_digit;
  logic              cand_is_digit;
  logic [3:0]        cand_value;

  // Maps a key code to {is_digit, decimal value}.
  function automatic logic [4:0] digit_of(input logic [3:0] code);
    case (code)
      4'd0:    digit_of = 5'h11;
      4'd1:    digit_of = 5'h12;
      4'd2:    digit_of = 5'h13;
      4'd4:    digit_of = 5'h14;
      4'd5:    digit_of = 5'h15;
      4'd6:    digit_of = 5'h16;
      4'd8:    digit_of = 5'h17;
      4'd9:    digit_of = 5'h18;
      4'd10:   digit_of = 5'h19;
      4'd13:   digit_of = 5'h10;
      default: digit_of = 5'h00;
    endcase
  endfunction

  // NOTE: reset asserts asynchronously but its release is passed through two
  // flops, so the FSM only starts leaving SCAN on a clean clock edge.
  always_ff @(posedge clk_100mhz or negedge reset) begin
    if (!reset) begin
      run_sync <= 2'b00;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge
      // values, so the shift register really is two stages deep.
      run_sync <= {run_sync[0], 1'b1};
    end
  end
  assign run = run_sync[1];

  // Columns are asynchronous to the clock; two flops before any use.
  always_ff @(posedge clk_100mhz or negedge reset) begin
    if (!reset) begin
      col_meta <= 4'hF;
      col_sync <= 4'hF;
    end else begin
      col_meta <= col_in;
      col_sync <= col_meta;
    end
  end

  // Lowest column index wins when several columns are low.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    col_idx = 2'd3;
    if (!col_sync[0])      col_idx = 2'd0;
    else if (!col_sync[1]) col_idx = 2'd1;
    else if (!col_sync[2]) col_idx = 2'd2;
  end

  assign col_any  = (col_sync != 4'hF);
  assign cur_code = {row_idx, col_idx};

  // FSM next state. The synchroniser delays columns by two cycles, so a press
  // is only trusted once settle_cnt shows the current row has been driven
  // long enough for its response to reach col_sync.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    case (state)
      SCAN: begin
        if (run && col_any && (settle_cnt == 2'd2)) begin
          state_next = DEBOUNCE;
          capture    = 1'b1;
        end
      end
      DEBOUNCE: begin
        if (!col_any || (cur_code != cand_code)) begin
          state_next = SCAN;
        end else if (deb_cnt == DEB_LAST) begin
          state_next = ACCEPT;
        end
      end
      ACCEPT: state_next = WAIT_RELEASE;
      WAIT_RELEASE: begin
        if (!col_any && (deb_cnt == DEB_LAST)) begin
          state_next = SCAN;
        end
      end
      default: state_next = SCAN;
    endcase
  end

  assign accept_now  = (state == DEBOUNCE) && (state_next == ACCEPT);
  assign row_advance = run && (state == SCAN) && (state_next == SCAN) &&
                       (scan_cnt == SCAN_LAST);

  // State, row scan and debounce counters.
  always_ff @(posedge clk_100mhz or negedge reset) begin
    if (!reset) begin
      state      <= SCAN;
      row_idx    <= 2'd0;
      row_out    <= 4'b1110;
      scan_cnt   <= '0;
      settle_cnt <= 2'd0;
      deb_cnt    <= '0;
      cand_code  <= 4'd0;
    end else begin
      state <= state_next;

      // Row drive only moves in SCAN; it stays frozen while a key is judged.
      if (run && (state == SCAN) && (state_next == SCAN)) begin
        scan_cnt <= (scan_cnt == SCAN_LAST) ? '0 : scan_cnt + 1'b1;
      end
      if (row_advance) begin
        row_idx    <= row_idx + 2'd1;
        row_out    <= {row_out[2:0], row_out[3]};
        settle_cnt <= 2'd0;
      end else if (settle_cnt != 2'd2) begin
        settle_cnt <= settle_cnt + 2'd1;
      end

      if (capture) begin
        cand_code <= cur_code;
      end

      // One counter serves both press and release qualification; it restarts
      // on every state change.
      if (state_next != state) begin
        deb_cnt <= '0;
      end else begin
        case (state)
          DEBOUNCE:     deb_cnt <= deb_cnt + 1'b1;
          WAIT_RELEASE: deb_cnt <= col_any ? '0 : deb_cnt + 1'b1;
          default:      deb_cnt <= '0;
        endcase
      end
    end
  end

  assign cand_digit    = digit_of(cand_code);
  assign cand_is_digit = cand_digit[4];
  assign cand_value    = cand_digit[3:0];

  // Key actions are registered on the edge entering ACCEPT, so key_pulse,
  // key_code and the number outputs all change together during ACCEPT.
  always_ff @(posedge clk_100mhz or negedge reset) begin
    if (!reset) begin
      key_pulse      <= 1'b0;
      key_code       <= 4'd0;
      number_valid   <= 1'b0;
      accum_number   <= 16'd0;
      digit_count    <= 3'd0;
      entered_number <= 16'd0;
    end else begin
      key_pulse    <= accept_now;
      number_valid <= 1'b0;
      if (accept_now) begin
        key_code <= cand_code;
        if (cand_is_digit) begin
          // Four digits max keeps the value at or below 9999.
          if (digit_count < 3'd4) begin
            accum_number <= (accum_number << 3) + (accum_number << 1) +
                            {12'd0, cand_value};
            digit_count  <= digit_count + 3'd1;
          end
        end else begin
          case (cand_code)
            KEY_HASH: begin
              entered_number <= accum_number;
              number_valid   <= 1'b1;
              accum_number   <= 16'd0;
              digit_count    <= 3'd0;
            end
            KEY_STAR: begin
              accum_number <= 16'd0;
              digit_count  <= 3'd0;
            end
`ifdef KEYPAD_BACKSPACE_EN
            KEY_D: begin
              if (digit_count != 3'd0) begin
                accum_number <= accum_number / 16'd10;
                digit_count  <= digit_count - 3'd1;
              end
            end
`endif
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_number_entry.sv
// -----------------------------------------------------------------------------
// tb_keypad_number_entry
//
// Self-checking bench for keypad_number_entry with SCAN_DIV=4 and
// DEBOUNCE_CYCLES=8. A keypad model answers row_out with col_in; each press
// pushes the expected outputs to a scoreboard that is popped on key_pulse.
// -----------------------------------------------------------------------------
module tb_keypad_number_entry;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;
  localparam int HOLD     = 40;
  localparam int RELEASE  = 30;

  logic        clk_100mhz = 1'b0;
  logic        reset      = 1'b0;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic [15:0] accum_number;
  logic [2:0]  digit_count;
  logic [15:0] entered_number;
  logic        number_valid;
  logic [3:0]  key_code;
  logic        key_pulse;

  always #5 clk_100mhz = ~clk_100mhz;

  keypad_number_entry #(
    .SCAN_DIV        (SCAN_DIV),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk_100mhz     (clk_100mhz),
    .reset          (reset),
    .col_in         (col_in),
    .row_out        (row_out),
    .accum_number   (accum_number),
    .digit_count    (digit_count),
    .entered_number (entered_number),
    .number_valid   (number_valid),
    .key_code       (key_code),
    .key_pulse      (key_pulse)
  );

  // Keypad matrix: the pressed key pulls its column low while its row is driven.
  logic       key_down = 1'b0;
  logic [1:0] key_row  = 2'd0;
  logic [1:0] key_col  = 2'd0;

  always_comb begin
    col_in = 4'hF;
    if (key_down && (row_out[key_row] == 1'b0)) col_in[key_col] = 1'b0;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model and scoreboard.
  typedef struct {
    logic [3:0]  code;
    logic [15:0] accum;
    logic [2:0]  count;
    logic        valid;
    logic [15:0] entered;
  } exp_t;

  exp_t  sb[$];
  string layout = "123A456B789C*0#D";
  int    m_accum   = 0;
  int    m_count   = 0;
  int    m_entered = 0;
  int    n_pushed  = 0;
  int    n_pulses  = 0;
  int    n_valid   = 0;

  task automatic model_key(input logic [3:0] code);
    byte  ch;
    exp_t e;
    ch = layout[code];
    e.valid = 1'b0;
    if (ch >= "0" && ch <= "9") begin
      if (m_count < 4) begin
        m_accum = m_accum * 10 + (int'(ch) - 48);
        m_count++;
      end
    end else if (ch == "#") begin
      m_entered = m_accum;
      m_accum   = 0;
      m_count   = 0;
      e.valid   = 1'b1;
    end else if (ch == "*") begin
      m_accum = 0;
      m_count = 0;
    end
`ifdef KEYPAD_BACKSPACE_EN
    else if (ch == "D") begin
      if (m_count > 0) begin
        m_accum = m_accum / 10;
        m_count--;
      end
    end
`endif
    e.code    = code;
    e.accum   = m_accum[15:0];
    e.count   = m_count[2:0];
    e.entered = m_entered[15:0];
    sb.push_back(e);
    n_pushed++;
  endtask

  function automatic logic [3:0] code_of(input byte ch);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 16; i++) if (layout[i] == ch) c = 4'(i);
    return c;
  endfunction

  task automatic press(input byte ch);
    logic [3:0] c;
    c = code_of(ch);
    model_key(c);
    key_row  = c[3:2];
    key_col  = c[1:0];
    key_down = 1'b1;
    repeat (HOLD) @(posedge clk_100mhz);
    key_down = 1'b0;
    repeat (RELEASE) @(posedge clk_100mhz);
  endtask

  // Output monitor, sampled on the falling edge.
  exp_t mon_e;
  always @(negedge clk_100mhz) begin
    if (reset) begin
      if (key_pulse) begin
        n_pulses++;
        if (sb.size() == 0) begin
          check("unexpected_pulse", 32'(key_code), 32'hFFFF);
        end else begin
          mon_e = sb.pop_front();
          check("key_code", 32'(key_code), 32'(mon_e.code));
          check("accum_number", 32'(accum_number), 32'(mon_e.accum));
          check("digit_count", 32'(digit_count), 32'(mon_e.count));
          check("number_valid", 32'(number_valid), 32'(mon_e.valid));
          check("entered_number", 32'(entered_number), 32'(mon_e.entered));
        end
      end
      if (number_valid) n_valid++;
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_row_out"}, 32'(row_out), 32'hE);
    check({tag, "_accum"}, 32'(accum_number), 0);
    check({tag, "_count"}, 32'(digit_count), 0);
    check({tag, "_entered"}, 32'(entered_number), 0);
    check({tag, "_key_code"}, 32'(key_code), 0);
    check({tag, "_valid"}, 32'(number_valid), 0);
    check({tag, "_pulse"}, 32'(key_pulse), 0);
  endtask

  initial begin
    logic [3:0] prev_row;
    int         changes;
    int         pulses_before;
    int         valid_before;
    bit         found;

    // Reset state.
    repeat (3) @(posedge clk_100mhz);
    #1;
    check_reset_values("rst");
    @(negedge clk_100mhz);
    reset = 1'b1;

    // Row rotation with no key pressed.
    prev_row = row_out;
    changes  = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_100mhz);
      if (row_out != prev_row) begin
        check("row_rotate", 32'(row_out), 32'({prev_row[2:0], prev_row[3]}));
        prev_row = row_out;
        changes++;
      end
    end
    check("row_changes_seen", 32'(changes >= 8), 1);

    // 1,2,3,4,# -> 1234 committed.
    valid_before = n_valid;
    press("1"); press("2"); press("3"); press("4"); press("#");
    check("entered_1234", 32'(entered_number), 1234);
    check("accum_after_commit", 32'(accum_number), 0);
    check("valid_once_1234", 32'(n_valid - valid_before), 1);

    // Bouncing '5' followed by a stable hold.
    pulses_before = n_pulses;
    model_key(code_of("5"));
    key_row = 2'd1;
    key_col = 2'd1;
    for (int i = 0; i < 6; i++) begin
      key_down = 1'b1;
      repeat (3) @(posedge clk_100mhz);
      key_down = 1'b0;
      repeat (2) @(posedge clk_100mhz);
    end
    key_down = 1'b1;
    repeat (HOLD) @(posedge clk_100mhz);
    key_down = 1'b0;
    repeat (RELEASE) @(posedge clk_100mhz);
    check("bounce_one_pulse", 32'(n_pulses - pulses_before), 1);
    check("bounce_key_code", 32'(key_code), 5);
    press("*");

    // Five nines: the fifth is ignored.
    for (int i = 0; i < 5; i++) press("9");
    check("accum_9999", 32'(accum_number), 9999);
    check("count_full", 32'(digit_count), 4);
    press("#");
    check("entered_9999", 32'(entered_number), 9999);

    // 987, D, #.
    press("9"); press("8"); press("7"); press("D"); press("#");
`ifdef KEYPAD_BACKSPACE_EN
    check("entered_backspace", 32'(entered_number), 98);
`else
    check("entered_no_backspace", 32'(entered_number), 987);
`endif

    // Reset in the middle of debouncing '7'.
    press("4");
    @(negedge clk_100mhz);
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(posedge clk_100mhz);
      #1;
      if (row_out == 4'b1101) found = 1'b1;
    end
    check("reach_row1", 32'(found), 1);
    key_row  = 2'd2;
    key_col  = 2'd0;
    key_down = 1'b1;
    found    = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(posedge clk_100mhz);
      #1;
      if (row_out == 4'b1011) found = 1'b1;
    end
    check("reach_row2", 32'(found), 1);
    repeat (5) @(posedge clk_100mhz);
    @(negedge clk_100mhz);
    reset = 1'b0;
    #1;
    check_reset_values("mid_rst");
    m_accum   = 0;
    m_count   = 0;
    m_entered = 0;
    repeat (3) @(posedge clk_100mhz);
    key_down = 1'b0;
    @(negedge clk_100mhz);
    reset = 1'b1;
    pulses_before = n_pulses;
    repeat (60) @(posedge clk_100mhz);
    check("no_pulse_after_reset", 32'(n_pulses - pulses_before), 0);

    // 42, *, # commits zero.
    press("4"); press("2");
    check("accum_42", 32'(accum_number), 42);
    press("*");
    valid_before = n_valid;
    press("#");
    check("entered_zero", 32'(entered_number), 0);
    check("valid_once_zero", 32'(n_valid - valid_before), 1);

    repeat (10) @(posedge clk_100mhz);
    check("scoreboard_empty", 32'(sb.size()), 0);
    check("pulse_total", 32'(n_pulses), 32'(n_pushed));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
